// File: rtl/ckgate_pkg.sv
// Shared types and helpers for the multi-channel clock-gating controller.
package ckgate_pkg;

  // Per-channel gating state.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_GATED = 2'd1,
    ST_WAKE  = 2'd2
  } ckg_state_e;

  // Default number of ungated cycles spent waking before RUN.
  localparam int WAKE_CYC_DEF = 2;

  // Width of a counter that must hold values 0..wake_cyc; never below one bit.
  function automatic int wake_cnt_width(input int wake_cyc);
    int w;
    w = $clog2(wake_cyc + 1);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  localparam int WAKE_CNT_W_DEF = wake_cnt_width(WAKE_CYC_DEF);

endpackage

// File: rtl/ckgate_chan.sv
// One clock-gating channel: idle/wake FSM, counters, status flops and the
// latch-plus-AND gate (kept together here so it can be swapped for an ICG cell).
module ckgate_chan
  import ckgate_pkg::*;
#(
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic              ck_i,
  input  logic              rn_i,
  input  logic              te_i,
  input  logic              e_i,
  input  logic              auto_en_i,
  input  logic              busy_i,
  input  logic              wreq_i,
  input  logic [IDLE_W-1:0] idle_lim_i,
  output logic              wack_o,
  output logic              gated_o,
  output logic              gck_o
);

  localparam int WCW = wake_cnt_width(WAKE_CYC);
  localparam logic [WCW-1:0] WAKE_LAST = WCW'(WAKE_CYC - 1);

  ckg_state_e        state_q, state_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [WCW-1:0]    wake_cnt_q, wake_cnt_d;
  logic              en_q;
  logic              wack_q;
  logic              gated_q;
  logic              latch_en_q;
  logic              idle_s;
  logic              wake_cause_s;

  // Wake causes always win over the idle path because idle excludes them all.
  assign idle_s       = auto_en_i & ~e_i & ~busy_i & ~wreq_i;
  assign wake_cause_s = busy_i | e_i | wreq_i | ~auto_en_i;

  // Next-state and counter update for the idle/wake sequencer.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (idle_s) begin
          if (idle_cnt_q == idle_lim_i) begin
            state_d    = ST_GATED;
            idle_cnt_d = {IDLE_W{1'b0}};
          end else begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          end
        end else begin
          idle_cnt_d = {IDLE_W{1'b0}};
        end
      end
      ST_GATED: begin
        if (wake_cause_s) begin
          state_d    = ST_WAKE;
          wake_cnt_d = {WCW{1'b0}};
        end else begin
          state_d    = ST_GATED;
        end
      end
      ST_WAKE: begin
        // Wake is never aborted: it runs its full length regardless of inputs.
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = ST_RUN;
          wake_cnt_d = {WCW{1'b0}};
        end else begin
          wake_cnt_d = wake_cnt_q + WCW'(1);
        end
      end
      default: begin
        state_d    = ST_RUN;
        idle_cnt_d = {IDLE_W{1'b0}};
        wake_cnt_d = {WCW{1'b0}};
      end
    endcase
  end

  // State, counters and registered outputs; enable tracks the next state so
  // the gate closes one edge after GATED is entered.
  always_ff @(posedge ck_i or negedge rn_i) begin
    if (!rn_i) begin
      state_q    <= ST_RUN;
      idle_cnt_q <= {IDLE_W{1'b0}};
      wake_cnt_q <= {WCW{1'b0}};
      en_q       <= 1'b1;
      wack_q     <= 1'b0;
      gated_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      en_q       <= (state_d != ST_GATED);
      wack_q     <= wreq_i & (state_q == ST_RUN);
      gated_q    <= (state_d == ST_GATED);
    end
  end

  // Glitch-free gate latch: follows the enable only while CK is low; reset
  // forces it open so the clock runs throughout reset.
  always_latch begin
    if (!rn_i) begin
      latch_en_q = 1'b1;
    end else if (!ck_i) begin
      latch_en_q = en_q | te_i;
    end
  end

  assign gck_o   = ck_i & latch_en_q;
  assign wack_o  = wack_q;
  assign gated_o = gated_q;

endmodule

// File: rtl/ckgate_ctrl_mc.sv
// Multi-channel clock-gating controller: NCH independent gated channels
// sharing only the source clock, reset, test enable and idle threshold.
module ckgate_ctrl_mc
  import ckgate_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = WAKE_CYC_DEF
) (
  input  logic              CK,
  input  logic              RN,
  input  logic              TE,
  input  logic [NCH-1:0]    E,
  input  logic [NCH-1:0]    AUTO_EN,
  input  logic [NCH-1:0]    BUSY,
  input  logic [IDLE_W-1:0] IDLE_LIM,
  input  logic [NCH-1:0]    WREQ,
  output logic [NCH-1:0]    WACK,
  output logic [NCH-1:0]    GATED,
  output logic [NCH-1:0]    GCK
);

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    ckgate_chan #(
      .IDLE_W   (IDLE_W),
      .WAKE_CYC (WAKE_CYC)
    ) u_chan (
      .ck_i       (CK),
      .rn_i       (RN),
      .te_i       (TE),
      .e_i        (E[g]),
      .auto_en_i  (AUTO_EN[g]),
      .busy_i     (BUSY[g]),
      .wreq_i     (WREQ[g]),
      .idle_lim_i (IDLE_LIM),
      .wack_o     (WACK[g]),
      .gated_o    (GATED[g]),
      .gck_o      (GCK[g])
    );
  end

endmodule

// File: tb/tb_ckgate_ctrl_mc.sv
// Bench for ckgate_ctrl_mc: per-cycle comparison against a behavioural model
// plus directed literal checks of latencies and pulse counts.
module tb_ckgate_ctrl_mc;

  localparam int NCH      = 4;
  localparam int IDLE_W   = 8;
  localparam int WAKE_CYC = 2;

  logic              CK;
  logic              RN;
  logic              TE;
  logic [NCH-1:0]    E;
  logic [NCH-1:0]    AUTO_EN;
  logic [NCH-1:0]    BUSY;
  logic [IDLE_W-1:0] IDLE_LIM;
  logic [NCH-1:0]    WREQ;
  logic [NCH-1:0]    WACK;
  logic [NCH-1:0]    GATED;
  logic [NCH-1:0]    GCK;

  int checks = 0;
  int errors = 0;
  int pc [NCH];

  ckgate_ctrl_mc #(.NCH(NCH), .IDLE_W(IDLE_W), .WAKE_CYC(WAKE_CYC)) dut (
    .CK(CK), .RN(RN), .TE(TE), .E(E), .AUTO_EN(AUTO_EN), .BUSY(BUSY),
    .IDLE_LIM(IDLE_LIM), .WREQ(WREQ), .WACK(WACK), .GATED(GATED), .GCK(GCK)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Model: "gated" flag, consecutive idle samples, wake cycles remaining.
  bit m_gated [NCH];
  bit m_waking[NCH];
  int m_idle_run[NCH];
  int m_wake_left[NCH];
  bit m_wack[NCH];
  bit m_gck_exp[NCH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge, then comparison a little later.
  always begin
    @(posedge CK);
    for (int i = 0; i < NCH; i++) begin
      bit open_before;
      bit in_run;
      bit idle;
      bit wake;
      open_before = !m_gated[i];
      if (!RN) begin
        m_gated[i] = 0; m_waking[i] = 0; m_idle_run[i] = 0;
        m_wake_left[i] = 0; m_wack[i] = 0; m_gck_exp[i] = 1;
      end else begin
        in_run = !m_gated[i] && !m_waking[i];
        idle   = AUTO_EN[i] && !E[i] && !BUSY[i] && !WREQ[i];
        wake   = !idle;
        m_wack[i] = WREQ[i] && in_run;
        if (m_gated[i]) begin
          if (wake) begin
            m_gated[i] = 0; m_waking[i] = 1; m_wake_left[i] = WAKE_CYC;
          end
        end else if (m_waking[i]) begin
          m_wake_left[i]--;
          if (m_wake_left[i] == 0) begin
            m_waking[i] = 0; m_idle_run[i] = 0;
          end
        end else if (idle) begin
          m_idle_run[i]++;
          if (m_idle_run[i] == int'(IDLE_LIM) + 1) begin
            m_gated[i] = 1; m_idle_run[i] = 0;
          end
        end else begin
          m_idle_run[i] = 0;
        end
        m_gck_exp[i] = open_before || TE;
      end
    end
    #2;
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("model_gated[%0d]", i), 32'(GATED[i]), 32'(m_gated[i]));
      chk($sformatf("model_wack[%0d]", i),  32'(WACK[i]),  32'(m_wack[i]));
      chk($sformatf("model_gck[%0d]", i),   32'(GCK[i]),   32'(m_gck_exp[i]));
    end
  end

  // Count high phases of each gated clock.
  initial for (int i = 0; i < NCH; i++) pc[i] = 0;
  always begin
    @(posedge CK);
    #2;
    for (int i = 0; i < NCH; i++) if (GCK[i]) pc[i]++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge CK);
  endtask

  int p0, p1, p3;
  int pa[NCH];

  initial begin
    RN = 1'b1; TE = 1'b0; E = 4'b1111; AUTO_EN = 4'b0000; BUSY = 4'b0000;
    WREQ = 4'b0000; IDLE_LIM = 8'd5;
    #1 RN = 1'b0;
    // Reset: 3 cycles, clocks run, status low.
    step(3);
    chk("rst_gated", 32'(GATED), 32'h0);
    chk("rst_wack", 32'(WACK), 32'h0);
    chk("rst_pulses0", 32'(pc[0]), 32'd3);
    RN = 1'b1;

    // Channel 0 auto-gates after 6 idle edges with IDLE_LIM=5.
    E = 4'b1110; AUTO_EN = 4'b0001;
    step(5);
    chk("ch0_not_yet", 32'(GATED), 32'h0);
    step(1);
    chk("ch0_gated", 32'(GATED), 32'h1);
    p0 = pc[0]; p1 = pc[1];
    step(5);
    chk("ch0_no_pulses", 32'(pc[0] - p0), 32'd0);
    chk("ch1_running", 32'(pc[1] - p1), 32'd5);

    // Gate the remaining channels.
    E = 4'b0000; AUTO_EN = 4'b1111;
    step(6);
    chk("all_gated", 32'(GATED), 32'hF);

    // Channel 1: one-cycle BUSY wakes it; pulse on the following edge.
    BUSY = 4'b0010;
    step(1);
    chk("ch1_waking", 32'(GATED), 32'hD);
    BUSY = 4'b0000;
    p1 = pc[1];
    step(1);
    chk("ch1_first_pulse", 32'(pc[1] - p1), 32'd1);
    step(1);                      // RUN reached here
    step(5);
    chk("ch1_not_regated", 32'(GATED[1]), 32'h0);
    step(1);
    chk("ch1_regated", 32'(GATED[1]), 32'h1);

    // Channel 2: WREQ handshake.
    WREQ = 4'b0100;
    step(1);
    chk("ch2_wack0", 32'(WACK), 32'h0);
    step(2);
    chk("ch2_wack_run", 32'(WACK), 32'h0);
    step(1);
    chk("ch2_wack1", 32'(WACK), 32'h4);
    WREQ = 4'b0000;
    step(1);
    chk("ch2_wack_drop", 32'(WACK), 32'h0);
    step(8);
    chk("all_gated2", 32'(GATED), 32'hF);

    // Test enable opens every gate while the FSM stays gated.
    TE = 1'b1;
    for (int i = 0; i < NCH; i++) pa[i] = pc[i];
    step(4);
    for (int i = 0; i < NCH; i++) chk($sformatf("te_pulses[%0d]", i), 32'(pc[i] - pa[i]), 32'd4);
    chk("te_gated", 32'(GATED), 32'hF);
    TE = 1'b0;
    for (int i = 0; i < NCH; i++) pa[i] = pc[i];
    step(3);
    for (int i = 0; i < NCH; i++) chk($sformatf("te_off[%0d]", i), 32'(pc[i] - pa[i]), 32'd0);

    // IDLE_LIM=0 on channel 3 with BUSY toggling.
    IDLE_LIM = 8'd0;
    BUSY = 4'b1000;
    step(1);
    BUSY = 4'b0000;
    step(2);                      // wake completes
    chk("ch3_run", 32'(GATED[3]), 32'h0);
    step(1);
    chk("ch3_lim0_gated", 32'(GATED[3]), 32'h1);
    for (int k = 0; k < 12; k++) begin
      BUSY[3] = ~BUSY[3];
      step(1);
    end
    BUSY[3] = 1'b1;
    step(1);
    chk("ch3_busy_wins", 32'(GATED[3]), 32'h0);
    BUSY[3] = 1'b0;

    // Reset in the middle of WAKE: clock runs on the reset edge.
    RN = 1'b0;
    p3 = pc[3];
    step(1);
    chk("midrst_gated", 32'(GATED), 32'h0);
    chk("midrst_pulse", 32'(pc[3] - p3), 32'd1);
    RN = 1'b1;
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
